// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// Carries the instruction/memory handshake inputs and every datapath strobe and select.
interface multicycle_controller_if #(
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
);
    logic [31:0]        Instruction;
    logic               MemReady;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               BranchNe;
    logic [1:0]         PCSrc;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic               Illegal;
    logic [CNT_W-1:0]   RetireCount;
    logic [3:0]         State;

    modport master (
        input  Instruction, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe, PCSrc, ALUSrcB,
               ALUOp, Illegal, RetireCount, State
    );

    modport slave (
        output Instruction, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe, PCSrc, ALUSrcB,
               ALUOp, Illegal, RetireCount, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// MIPS-subset multicycle control FSM: 3-5 cycles per instruction at zero wait states.
// FETCH/MEM_RD/MEM_WR hold with strobes asserted while MemReady is low; counts retired instructions.
module multicycle_controller #(
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_LD  = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(6'b100000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6'b100010);

    state_e             state_q, state_d;
    logic               is_store_q, is_store_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic               retire;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               unused_instr_bits;

    assign opcode            = bus.Instruction[31:26];
    assign funct             = bus.Instruction[5:0];
    assign unused_instr_bits = ^bus.Instruction[25:6];

    assign bus.State       = state_q;
    assign bus.RetireCount = retire_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            retire_q   <= retire_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        is_store_d      = is_store_q;
        retire          = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.PCSrc       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = ALU_ADD;
        bus.Illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively here and parked in ALUOut.
                bus.ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE: state_d = S_EXEC_R;
                    OP_ADDI:  state_d = S_EXEC_I;
                    OP_LW: begin
                        state_d    = S_ADDR;
                        is_store_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d    = S_ADDR;
                        is_store_d = 1'b1;
                    end
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_W'(funct);
                state_d     = S_WB_R;
            end
            S_WB_R: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = S_WB_I;
            end
            S_WB_I: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDR: begin
                // lw/sw split uses the flag latched in DECODE, not the live IR.
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = is_store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) state_d = S_WB_LD;
            end
            S_WB_LD: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSrc       = 2'b01;
                bus.BranchNe    = (opcode == OP_BNE);
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b10;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                bus.Illegal = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        retire_d = retire ? retire_q + CNT_W'(1) : retire_q;

        // Reset can land in any state; suppress side effects until it releases.
        if (Rst) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.Illegal     = 1'b0;
            bus.BranchNe    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default-width DUT plus a CNT_W=4 copy for counter wrap.
module tb_multicycle_controller;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_WB_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4;
    localparam logic [3:0] S_WB_I   = 4'd5;
    localparam logic [3:0] S_ADDR   = 4'd6;
    localparam logic [3:0] S_MEM_RD = 4'd7;
    localparam logic [3:0] S_WB_LD  = 4'd8;
    localparam logic [3:0] S_MEM_WR = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BNE  = 32'h1422_0003;
    localparam logic [31:0] I_ADDI = 32'h2022_0010;
    localparam logic [31:0] I_J    = 32'h0800_0040;
    localparam logic [31:0] I_ILL  = 32'hFC00_0020;

    logic Clk;
    logic Rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   c0;
    int   exp_cnt;

    multicycle_controller_if #(.ALUOP_W(6), .CNT_W(16)) bus();
    multicycle_controller_if #(.ALUOP_W(6), .CNT_W(4))  bus4();

    assign bus4.Instruction = bus.Instruction;
    assign bus4.MemReady    = bus.MemReady;

    multicycle_controller #(.ALUOP_W(6), .CNT_W(16)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    multicycle_controller #(.ALUOP_W(6), .CNT_W(4)) u_dut4 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] ins, input logic rdy);
        bus.Instruction = ins;
        bus.MemReady    = rdy;
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"},  32'(bus.RetireCount),  32'(exp_cnt % 65536));
        chk({tag, "_cnt4"}, 32'(bus4.RetireCount), 32'(exp_cnt % 16));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; exp_cnt = 0;
        Rst = 1'b1;
        bus.Instruction = I_ADD;
        bus.MemReady    = 1'b1;

        // Reset: strobes silenced while held, state/counter cleared.
        tick(); tick();
        chk("rst_memrd", 32'(bus.MemRead), 0);
        chk("rst_irw",   32'(bus.IRWrite), 0);
        chk("rst_pcw",   32'(bus.PCWrite), 0);
        chk("rst_state", 32'(bus.State), 32'(S_FETCH));
        chk_cnt("rst");
        Rst = 1'b0;
        #1;
        chk("rel_memrd", 32'(bus.MemRead), 1);
        chk("rel_state", 32'(bus.State), 32'(S_FETCH));

        // add
        drive(I_ADD, 1'b1);
        c0 = cyc;
        chk("add_f_irw",  32'(bus.IRWrite), 1);
        chk("add_f_pcw",  32'(bus.PCWrite), 1);
        chk("add_f_srcb", 32'(bus.ALUSrcB), 1);
        tick();
        chk("add_dec",      32'(bus.State), 32'(S_DECODE));
        chk("add_dec_srcb", 32'(bus.ALUSrcB), 3);
        tick();
        chk("add_exr",      32'(bus.State), 32'(S_EXEC_R));
        chk("add_exr_op",   32'(bus.ALUOp), 32'h20);
        chk("add_exr_srca", 32'(bus.ALUSrcA), 1);
        tick();
        chk("add_wbr",    32'(bus.State), 32'(S_WB_R));
        chk("add_wbr_rw", 32'(bus.RegWrite), 1);
        chk("add_wbr_rd", 32'(bus.RegDst), 1);
        chk_cnt("add_wbr");
        tick();
        exp_cnt++;
        chk("add_cycles", 32'(cyc - c0), 4);
        chk("add_done",   32'(bus.State), 32'(S_FETCH));
        chk_cnt("add");

        // lw with two wait cycles in MEM_RD; IR scrambled after DECODE
        drive(I_LW, 1'b1);
        c0 = cyc;
        tick();
        tick();
        chk("lw_addr",      32'(bus.State), 32'(S_ADDR));
        chk("lw_addr_srcb", 32'(bus.ALUSrcB), 2);
        drive(I_ILL, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(I_ILL, (k == 2));
            chk("lw_mrd_state", 32'(bus.State), 32'(S_MEM_RD));
            chk("lw_mrd_memrd", 32'(bus.MemRead), 1);
            chk("lw_mrd_iord",  32'(bus.IorD), 1);
            tick();
        end
        chk("lw_wbld",    32'(bus.State), 32'(S_WB_LD));
        chk("lw_wbld_m2r", 32'(bus.MemtoReg), 1);
        chk("lw_wbld_rw",  32'(bus.RegWrite), 1);
        chk("lw_wbld_rd",  32'(bus.RegDst), 0);
        tick();
        exp_cnt++;
        chk("lw_cycles", 32'(cyc - c0), 7);
        chk_cnt("lw");

        // sw with one wait cycle in FETCH
        drive(I_SW, 1'b0);
        c0 = cyc;
        chk("sw_fw_irw",   32'(bus.IRWrite), 0);
        chk("sw_fw_pcw",   32'(bus.PCWrite), 0);
        chk("sw_fw_memrd", 32'(bus.MemRead), 1);
        tick();
        drive(I_SW, 1'b1);
        chk("sw_f_state", 32'(bus.State), 32'(S_FETCH));
        chk("sw_f_irw",   32'(bus.IRWrite), 1);
        tick(); tick(); tick();
        chk("sw_mwr",       32'(bus.State), 32'(S_MEM_WR));
        chk("sw_mwr_memwr", 32'(bus.MemWrite), 1);
        chk("sw_mwr_iord",  32'(bus.IorD), 1);
        tick();
        exp_cnt++;
        chk("sw_cycles", 32'(cyc - c0), 5);
        chk_cnt("sw");

        // bne then beq
        for (int b = 0; b < 2; b++) begin
            drive((b == 0) ? I_BNE : I_BEQ, 1'b1);
            c0 = cyc;
            tick(); tick();
            chk("br_state", 32'(bus.State), 32'(S_BRANCH));
            chk("br_pwc",   32'(bus.PCWriteCond), 1);
            chk("br_op",    32'(bus.ALUOp), 32'h22);
            chk("br_pcsrc", 32'(bus.PCSrc), 1);
            chk("br_ne",    32'(bus.BranchNe), (b == 0) ? 32'd1 : 32'd0);
            tick();
            exp_cnt++;
            chk("br_cycles", 32'(cyc - c0), 3);
            chk_cnt("br");
        end

        // addi
        drive(I_ADDI, 1'b1);
        c0 = cyc;
        tick(); tick();
        chk("addi_exi",      32'(bus.State), 32'(S_EXEC_I));
        chk("addi_exi_srcb", 32'(bus.ALUSrcB), 2);
        chk("addi_exi_op",   32'(bus.ALUOp), 32'h20);
        tick();
        chk("addi_wbi_rw", 32'(bus.RegWrite), 1);
        chk("addi_wbi_rd", 32'(bus.RegDst), 0);
        tick();
        exp_cnt++;
        chk("addi_cycles", 32'(cyc - c0), 4);
        chk_cnt("addi");

        // illegal opcode
        drive(I_ILL, 1'b1);
        c0 = cyc;
        tick(); tick();
        chk("ill_trap",  32'(bus.State), 32'(S_TRAP));
        chk("ill_pulse", 32'(bus.Illegal), 1);
        chk("ill_rw",    32'(bus.RegWrite), 0);
        chk("ill_mw",    32'(bus.MemWrite), 0);
        chk("ill_pcw",   32'(bus.PCWrite), 0);
        chk("ill_pwc",   32'(bus.PCWriteCond), 0);
        tick();
        chk("ill_cycles", 32'(cyc - c0), 3);
        chk("ill_clear",  32'(bus.Illegal), 0);
        chk_cnt("ill");

        // reset while MEM_WR is waiting on MemReady
        drive(I_SW, 1'b1);
        tick(); tick();
        drive(I_SW, 1'b0);
        tick();
        chk("rmw_wait1", 32'(bus.MemWrite), 1);
        tick();
        chk("rmw_wait2",  32'(bus.MemWrite), 1);
        chk("rmw_state",  32'(bus.State), 32'(S_MEM_WR));
        Rst = 1'b1;
        #1;
        chk("rmw_gate", 32'(bus.MemWrite), 0);
        tick();
        Rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rmw_state_after", 32'(bus.State), 32'(S_FETCH));
        chk("rmw_memwr_after", 32'(bus.MemWrite), 0);
        chk("rmw_memrd_after", 32'(bus.MemRead), 1);
        chk_cnt("rmw");

        // 16 jumps: narrow counter wraps 15 -> 0, wide one reaches 16
        for (int j = 0; j < 16; j++) begin
            drive(I_J, 1'b1);
            c0 = cyc;
            tick(); tick();
            chk("j_state", 32'(bus.State), 32'(S_JUMP));
            chk("j_pcw",   32'(bus.PCWrite), 1);
            chk("j_pcsrc", 32'(bus.PCSrc), 2);
            tick();
            exp_cnt++;
            chk("j_cycles", 32'(cyc - c0), 3);
            chk_cnt("j");
        end
        chk("wrap_cnt4", 32'(bus4.RetireCount), 0);
        chk("wrap_cnt",  32'(bus.RetireCount), 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_W, default 6, width of ALUOp (legal range 6..8); 6-bit codes zero-extended.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset; synchronous, active-high.
REQ-005 Instruction  in  32  IR contents; opcode [31:26], funct [5:0].
REQ-006 MemReady  in  1  memory handshake; 1 = current read/write completes this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath strobes.
REQ-008 MemtoReg, RegDst, RegWrite, ALUSrcA, BranchNe  out  1 each  datapath selects/strobes.
REQ-009 PCSrc  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-010 ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-011 ALUOp  out  ALUOP_W  ALU function code (MIPS funct encoding).
REQ-012 Illegal  out  1  one-cycle pulse: unsupported opcode decoded.
REQ-013 RetireCount  out  CNT_W  count of completed legal instructions.
REQ-014 State  out  4  current state encoding, debug only.

Function
REQ-015 Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 001000 addi, 000010 j; any other is illegal.
REQ-016 States: FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, JUMP, TRAP.
REQ-017 Every strobe/select not listed for a state SHALL be 0; ALUOp default 100000 (add).
REQ-018 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00; IRWrite=PCWrite=1 only when MemReady=1; leave to DECODE only when MemReady=1, else hold FETCH.
REQ-019 DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut); next state by opcode: R->EXEC_R, addi->EXEC_I, lw/sw->ADDR, beq/bne->BRANCH, j->JUMP, illegal->TRAP.
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=funct; -> WB_R. WB_R: RegDst=1, RegWrite=1, MemtoReg=0; -> FETCH.
REQ-021 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=add; -> WB_I. WB_I: RegDst=0, RegWrite=1, MemtoReg=0; -> FETCH.
REQ-022 ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add; lw->MEM_RD, sw->MEM_WR.
REQ-023 MEM_RD: MemRead=1, IorD=1; hold until MemReady=1, then -> WB_LD. WB_LD: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-024 MEM_WR: MemWrite=1, IorD=1; hold until MemReady=1, then -> FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100010 (sub), PCWriteCond=1, PCSrc=01, BranchNe=1 for bne, 0 for beq; -> FETCH.
REQ-026 JUMP: PCWrite=1, PCSrc=10; -> FETCH.
REQ-027 TRAP: Illegal=1 for exactly this cycle, no register/memory/PC write; -> FETCH; RetireCount unchanged.
REQ-028 Zero-wait latencies: R/addi/sw 4 cycles, lw 5, beq/bne/j 3, illegal 3; each MemReady=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
REQ-029 MemRead/MemWrite SHALL stay asserted, address select stable, for every wait cycle of a held state.
REQ-030 RetireCount increments by 1 on the final cycle of each legal instruction (WB_R, WB_I, WB_LD, MEM_WR with MemReady, BRANCH, JUMP); wraps from 2^CNT_W-1 to 0.
REQ-031 Instruction is sampled only in DECODE (decision) and EXEC_R/BRANCH (funct, BranchNe); changes elsewhere have no effect.

Reset
REQ-032 Rst=1 at a rising edge: State<=FETCH, RetireCount<=0, regardless of current state or pending MemReady handshake.
REQ-033 While Rst=1 all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite), Illegal and BranchNe SHALL be 0.
REQ-034 First cycle after Rst deasserts is FETCH with MemRead=1.

Verification
REQ-035 add (000000/100000), MemReady=1 -> FETCH,DECODE,EXEC_R(ALUOp=100000),WB_R(RegWrite=1,RegDst=1); RetireCount 0->1.
REQ-036 lw with MemReady low 2 cycles in MEM_RD -> 7 cycles total, MemRead=1 held 3 MEM_RD cycles, WB_LD MemtoReg=1.
REQ-037 bne then beq -> 3 cycles each, PCWriteCond=1, ALUOp=100010, BranchNe=1 then 0.
REQ-038 opcode 111111 -> TRAP, Illegal high one cycle, no write strobe, RetireCount unchanged.
REQ-039 Rst=1 during MEM_WR wait -> next cycle FETCH, MemWrite=0, RetireCount=0.
REQ-040 CNT_W=4, 16 jumps -> RetireCount wraps 15->0.
